// File: rtl/kill_sequencer.sv
// kill_sequencer: gathers simultaneous per-enemy kill strobes and replays them
// to the scoreboard as a one-pulse-per-clock `killed` stream.
module kill_sequencer #(
   parameter int unsigned N_ENEMIES = 8,
   parameter int unsigned PEND_W    = 5,
   parameter int unsigned EDGE      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [N_ENEMIES-1:0] hit,
   output logic                 killed,
   output logic [PEND_W-1:0]    pending,
   output logic                 dropped
);

   localparam int unsigned CNT_W = $clog2(N_ENEMIES + 1);
   localparam int unsigned TOT_W = PEND_W + CNT_W;
   localparam logic [TOT_W-1:0] PEND_MAX = {{CNT_W{1'b0}}, {PEND_W{1'b1}}};

   logic [N_ENEMIES-1:0] hit_q;
   logic [N_ENEMIES-1:0] hit_new;
   logic [CNT_W-1:0]     n_new;
   logic [TOT_W-1:0]     total;
   logic [TOT_W-1:0]     rem;
   logic                 issue;
   logic                 sat;

   // Qualify hits: rising edges only, or every high cycle in level mode
   always_comb begin
      hit_new = (EDGE != 0) ? (hit & ~hit_q) : hit;
   end

   // Count newly qualified kills this cycle
   always_comb begin
      n_new = '0;
      for (int i = 0; i < int'(N_ENEMIES); i++) begin
         n_new = n_new + CNT_W'(hit_new[i]);
      end
   end

   // Queue arithmetic at full width so the sum never wraps before saturation
   always_comb begin
      total = TOT_W'(pending) + TOT_W'(n_new);
      issue = enable & (total != '0);
      rem   = total - TOT_W'(issue);
      sat   = (rem > PEND_MAX);
   end

   // Hit history always tracks the input, even through clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_q <= '0;
      end else begin
         hit_q <= hit;
      end
   end

   // Pending counter, issued strobe and sticky overflow flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         killed  <= 1'b0;
         pending <= '0;
         dropped <= 1'b0;
      end else if (clear) begin
         killed  <= 1'b0;
         pending <= '0;
         dropped <= 1'b0;
      end else begin
         killed <= issue;
         if (sat) begin
            pending <= PEND_W'(PEND_MAX);
            dropped <= 1'b1;
         end else begin
            pending <= PEND_W'(rem);
         end
      end
   end

endmodule

// File: tb/tb_kill_sequencer.sv
// Directed bench for kill_sequencer: edge-mode and level-mode instances share stimulus.
module tb_kill_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       enable;
   logic [7:0] hit;

   logic       killed_e, dropped_e;
   logic [4:0] pending_e;
   logic       killed_l, dropped_l;
   logic [4:0] pending_l;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #10 clk = ~clk;

   kill_sequencer #(.N_ENEMIES(8), .PEND_W(5), .EDGE(1)) u_edge (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .hit(hit),
      .killed(killed_e), .pending(pending_e), .dropped(dropped_e)
   );

   kill_sequencer #(.N_ENEMIES(8), .PEND_W(5), .EDGE(0)) u_lvl (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .hit(hit),
      .killed(killed_l), .pending(pending_l), .dropped(dropped_l)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step n cycles, counting edge-mode pulses
   task automatic count_edge(input int n, output int unsigned cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         step();
         cnt += 32'(killed_e);
      end
   endtask

   task automatic count_lvl(input int n, output int unsigned cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         step();
         cnt += 32'(killed_l);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      int unsigned cnt;
      int unsigned exp_p;
      reset  = 1'b0;
      clear  = 1'b0;
      enable = 1'b1;
      hit    = 8'h00;
      #35;
      check("reset_killed", 32'(killed_e), 0);
      check("reset_pending", 32'(pending_e), 0);
      check("reset_dropped", 32'(dropped_e), 0);
      reset = 1'b1;
      step();

      // Single kill
      hit = 8'h01;
      step();
      check("single_killed", 32'(killed_e), 1);
      check("single_pending", 32'(pending_e), 0);
      hit = 8'h00;
      step();
      check("single_done", 32'(killed_e), 0);
      check("single_dropped", 32'(dropped_e), 0);

      // Three simultaneous kills
      hit = 8'h0B;
      step();
      check("sim3_p2", 32'(pending_e), 2);
      check("sim3_k1", 32'(killed_e), 1);
      hit = 8'h00;
      step();
      check("sim3_p1", 32'(pending_e), 1);
      check("sim3_k2", 32'(killed_e), 1);
      step();
      check("sim3_p0", 32'(pending_e), 0);
      check("sim3_k3", 32'(killed_e), 1);
      step();
      check("sim3_end", 32'(killed_e), 0);

      // Held level counts once in edge mode
      hit = 8'h10;
      count_edge(6, cnt);
      hit = 8'h00;
      begin
         int unsigned c2;
         count_edge(3, c2);
         cnt += c2;
      end
      check("held_once", cnt, 1);
      hit = 8'h10;
      count_edge(4, cnt);
      hit = 8'h00;
      begin
         int unsigned c2;
         count_edge(3, c2);
         cnt += c2;
      end
      check("held_again", cnt, 1);

      // Saturation in level mode
      do_clear();
      step();
      check("sat_clean", 32'(pending_l), 0);
      hit = 8'hFF;
      exp_p = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         exp_p = exp_p + 8 - 1;
         if (exp_p > 31) exp_p = 31;
         check("sat_pending", 32'(pending_l), exp_p);
         check("sat_killed", 32'(killed_l), 1);
      end
      check("sat_dropped", 32'(dropped_l), 1);
      hit = 8'h00;
      count_lvl(40, cnt);
      check("sat_drain", cnt, 31);
      check("sat_idle", 32'(killed_l), 0);
      check("sat_sticky", 32'(dropped_l), 1);
      do_clear();
      check("sat_clr_drop", 32'(dropped_l), 0);

      // Pause then release
      do_clear();
      enable = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         hit = 8'h01 << i;
         step();
         cnt += 32'(killed_e);
         hit = 8'h00;
         step();
         cnt += 32'(killed_e);
      end
      check("pause_nopulse", cnt, 0);
      check("pause_pending", 32'(pending_e), 4);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rel_killed", 32'(killed_e), 1);
         check("rel_pending", 32'(pending_e), 32'(3 - i));
      end
      step();
      check("rel_end", 32'(killed_e), 0);

      // Pause again, then clear with a hit in the same cycle held afterwards
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hit = 8'h02;
         step();
         hit = 8'h00;
         step();
      end
      check("pause2_pending", 32'(pending_e), 3);
      hit   = 8'h01;
      clear = 1'b1;
      step();
      clear  = 1'b0;
      check("clr_pending", 32'(pending_e), 0);
      check("clr_killed", 32'(killed_e), 0);
      enable = 1'b1;
      count_edge(5, cnt);
      hit = 8'h00;
      check("clr_nopulse", cnt, 0);

      // Asynchronous reset mid-burst
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         hit = 8'h04;
         step();
         hit = 8'h00;
         step();
      end
      check("ar_pending5", 32'(pending_e), 5);
      enable = 1'b1;
      step();
      check("ar_k_before", 32'(killed_e), 1);
      #4;
      reset = 1'b0;
      #1;
      check("ar_killed", 32'(killed_e), 0);
      check("ar_pending", 32'(pending_e), 0);
      check("ar_dropped_l", 32'(dropped_l), 0);
      step();
      check("ar_hold", 32'(killed_e), 0);
      reset = 1'b1;
      count_edge(4, cnt);
      check("ar_nopulse", cnt, 0);

      // Twelve kills conserved end to end
      hit = 8'hFF;
      step();
      cnt = 32'(killed_e);
      hit = 8'h00;
      step();
      cnt += 32'(killed_e);
      hit = 8'h0F;
      begin
         int unsigned c2;
         count_edge(20, c2);
         cnt += c2;
      end
      hit = 8'h00;
      check("conserve12", cnt, 12);
      check("conserve_drop", 32'(dropped_e), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
